rs_issue_scheduler: RTL and testbench
=====================================

Name: rs_issue_scheduler

Overview:
- Select/issue controller for the reservation-station array (one entry per slot, each tagged ALU/Load/Store/FloatingPoint).
- Each cycle, per FU type, picks the oldest valid, operand-ready entry whose FU can accept work.
- Registers the grant toward the FU and tells the RS which entries to free.
- Owns age ordering and occupancy timing for the non-pipelined FP unit; sits between the RS storage and the execute stage.

Parameters:
NUM_ENTRIES, 5, number of RS entries tracked
IDX_W, 3, width of an entry index (clog2 of NUM_ENTRIES, min 1)
FP_LATENCY, 4, cycles the FP unit stays busy after accepting an instruction (>=1)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
entry_valid  in  NUM_ENTRIES  entry i holds an instruction (RS busy bit)
entry_ready  in  NUM_ENTRIES  both source operands of entry i available
entry_fu  in  2*NUM_ENTRIES  FU type of entry i in bits [2i+1:2i]: 00 ALU, 01 Load, 10 Store, 11 FloatingPoint
entry_alloc  in  NUM_ENTRIES  one-cycle pulse: RS writes a new instruction into entry i this cycle
fu_ready  in  4  FU type t can accept an instruction this cycle (indexed by FU code)
issue_valid  out  4  registered: instruction issued to FU type t this cycle
issue_idx  out  4*IDX_W  registered: entry index issued to FU type t, bits [(t+1)*IDX_W-1:t*IDX_W]
entry_clear  out  NUM_ENTRIES  registered: RS must free entry i (same cycle as its issue_valid)
fp_busy  out  1  FP unit occupied; no FP issue possible

Behaviour:
- Reset (reset=0, async): issue_valid=0, issue_idx=0, entry_clear=0, fp_busy=0, age matrix=0, issued mask=0, FP counter=0. Reset mid-operation drops all in-flight grants immediately; the RS is responsible for its own flush.
- Age matrix older[i][j] (i!=j). On entry_alloc[i]: row i cleared, column i set (every other entry older than i).
- Simultaneous allocs in one cycle: the lower index is older than the higher.
- Eligibility of entry i for type t: entry_valid[i] & entry_ready[i] & entry_fu[i]==t & !issued[i] & !entry_alloc[i] & fu_ready[t].
- Additional condition for t=FloatingPoint: !fp_busy.
- Select (combinational): the eligible entry for type t with no older eligible entry of the same type. At most one per type; the four types are selected independently in the same cycle, so up to 4 issues per cycle.
- Latency: eligibility sampled in cycle N; issue_valid[t], issue_idx[t] and entry_clear[i] are asserted in cycle N+1 for exactly one cycle. With no grant, issue_valid[t]=0 and issue_idx[t] holds 0.
- issued[i] is set on grant and holds while entry_valid[i]=1. It clears when entry_valid[i]=0 or entry_alloc[i]=1, which prevents re-issue during the RS free delay.
- FP occupancy: on an FP grant in cycle N, the counter loads FP_LATENCY. fp_busy=1 while counter!=0; the counter decrements each cycle. The next FP issue is therefore at the earliest granted in cycle N+FP_LATENCY+1.
- fu_ready=0 for type t: no grant, and entries wait without losing age.
- No wrap-around: age is relational, not counter-based.
- Entry with entry_valid=0 but entry_ready=1: never selected.
- entry_alloc and entry_valid both high on the same entry: alloc wins. The entry is not eligible that cycle; it is youngest from the next cycle.

Test Plan:
- Reset with reset=0 while the entry_* inputs are active -> all outputs 0 asynchronously; after release with no inputs -> issue_valid=4'b0000 for 10 cycles.
- Allocate entry 3 then entry 1 (both Load, ready, fu_ready=4'b1111) -> cycle after eligibility: issue_valid=4'b0010, Load issue_idx=3, entry_clear=5'b01000; once entry 3 invalid, entry 1 issued with entry_clear=5'b00010.
- Same-cycle ready ALU entry 0, Load 1, Store 2, FP 4 -> one cycle later issue_valid=4'b1111, issue_idx={4,2,1,0}, entry_clear=5'b10111.
- Two ready FP entries, FP_LATENCY=4: first issued in cycle N+1, fp_busy=1 for 4 cycles, second issued in cycle N+6, never earlier.
- Store entry ready with fu_ready[2]=0 for 3 cycles, then 1 -> no Store issue during the stall; issue one cycle after fu_ready rises; entry_valid held high 2 more cycles -> no duplicate issue.
- Simultaneous alloc of entries 2 and 4 (ALU, ready next cycle) -> entry 2 issued first, entry 4 issued after entry 2 is freed.

Source files
------------

// File: rtl/rs_issue_scheduler.sv
// Reservation-station select/issue controller: per-FU-type oldest-ready pick,
// relational age matrix, registered grants and FP unit occupancy tracking.

module rs_issue_pick #(
  parameter int NUM_ENTRIES = 5,
  parameter int IDX_W       = 3
) (
  input  logic [NUM_ENTRIES-1:0]                  elig_i,
  input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_i,
  output logic [NUM_ENTRIES-1:0]                  gnt_o,
  output logic                                    vld_o,
  output logic [IDX_W-1:0]                        idx_o
);

  // beaten_by[i][j]: entry j takes priority over entry i. Entries with no
  // recorded order (never allocated since reset) fall back to lower index.
  // The age diagonal is always zero, so an entry never beats itself.
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] beaten_by;

  for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_row
    for (genvar j = 0; j < NUM_ENTRIES; j++) begin : g_col
      assign beaten_by[i][j] = older_i[j][i] |
                               (~older_i[i][j] & ((j < i) ? 1'b1 : 1'b0));
    end
    assign gnt_o[i] = elig_i[i] & ~|(elig_i & beaten_by[i]);
  end

  assign vld_o = |gnt_o;

  always_comb begin
    idx_o = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (gnt_o[i]) idx_o = idx_o | IDX_W'(i);
  end

endmodule

module rs_issue_scheduler #(
  parameter int NUM_ENTRIES = 5,
  parameter int IDX_W       = 3,
  parameter int FP_LATENCY  = 4
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic [NUM_ENTRIES-1:0]   entry_valid_i,
  input  logic [NUM_ENTRIES-1:0]   entry_ready_i,
  input  logic [2*NUM_ENTRIES-1:0] entry_fu_i,
  input  logic [NUM_ENTRIES-1:0]   entry_alloc_i,
  input  logic [3:0]               fu_ready_i,
  output logic [3:0]               issue_valid_o,
  output logic [4*IDX_W-1:0]       issue_idx_o,
  output logic [NUM_ENTRIES-1:0]   entry_clear_o,
  output logic                     fp_busy_o
);

  localparam int NUM_FU = 4;
  localparam int FU_FP  = 3;
  localparam int CNT_W  = $clog2(FP_LATENCY + 1);

  typedef struct packed {
    logic             vld;
    logic [IDX_W-1:0] idx;
  } grant_t;

  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_q, older_d;
  logic [NUM_ENTRIES-1:0]                  issued_q, issued_d;
  logic [NUM_ENTRIES-1:0]                  clear_q, clear_d;
  logic [CNT_W-1:0]                        fp_cnt_q, fp_cnt_d;
  grant_t [NUM_FU-1:0]                     gnt_q, gnt_d;

  logic                                    fp_busy;
  logic [NUM_FU-1:0]                       fu_ok;
  logic [NUM_FU-1:0][NUM_ENTRIES-1:0]      elig;
  logic [NUM_FU-1:0][NUM_ENTRIES-1:0]      pick;
  logic [NUM_FU-1:0]                       pick_vld;
  logic [NUM_FU-1:0][IDX_W-1:0]            pick_idx;

  assign fp_busy = (fp_cnt_q != '0);
  assign fu_ok   = fu_ready_i & ~{fp_busy, 3'b000};

  for (genvar t = 0; t < NUM_FU; t++) begin : g_fu
    for (genvar i = 0; i < NUM_ENTRIES; i++) begin : g_ent
      assign elig[t][i] = entry_valid_i[i] & entry_ready_i[i] &
                          (entry_fu_i[2*i +: 2] == 2'(t)) &
                          ~issued_q[i] & ~entry_alloc_i[i] & fu_ok[t];
    end

    rs_issue_pick #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .IDX_W       (IDX_W)
    ) u_pick (
      .elig_i  (elig[t]),
      .older_i (older_q),
      .gnt_o   (pick[t]),
      .vld_o   (pick_vld[t]),
      .idx_o   (pick_idx[t])
    );

    assign gnt_d[t]                          = '{vld: pick_vld[t], idx: pick_idx[t]};
    assign issue_valid_o[t]                  = gnt_q[t].vld;
    assign issue_idx_o[t*IDX_W +: IDX_W]     = gnt_q[t].idx;
  end

  always_comb begin
    clear_d = '0;
    for (int t = 0; t < NUM_FU; t++) clear_d = clear_d | pick[t];
  end

  // A new allocation becomes youngest; allocations in the same cycle are
  // ordered by index, lower index older.
  always_comb begin
    older_d = older_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (i == j)                                 older_d[i][j] = 1'b0;
        else if (entry_alloc_i[i] && entry_alloc_i[j]) older_d[i][j] = (i < j);
        else if (entry_alloc_i[i])                  older_d[i][j] = 1'b0;
        else if (entry_alloc_i[j])                  older_d[i][j] = 1'b1;
      end
    end
  end

  // Issued bit masks the entry until the RS drops valid or reallocates it.
  assign issued_d = ~entry_alloc_i & entry_valid_i & (issued_q | clear_d);

  always_comb begin
    fp_cnt_d = fp_cnt_q;
    if (pick_vld[FU_FP])  fp_cnt_d = CNT_W'(FP_LATENCY);
    else if (fp_busy)     fp_cnt_d = fp_cnt_q - 1'b1;
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      older_q  <= '0;
      issued_q <= '0;
      clear_q  <= '0;
      fp_cnt_q <= '0;
      gnt_q    <= '0;
    end else begin
      older_q  <= older_d;
      issued_q <= issued_d;
      clear_q  <= clear_d;
      fp_cnt_q <= fp_cnt_d;
      gnt_q    <= gnt_d;
    end
  end

  assign entry_clear_o = clear_q;
  assign fp_busy_o     = fp_busy;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// Directed bench for rs_issue_scheduler with an age-stamp reference model
// checked every cycle plus hand-computed expectations per scenario.

module tb_rs_issue_scheduler;

  localparam int NE  = 5;
  localparam int IW  = 3;
  localparam int FPL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [NE-1:0]   ev = '0, er = '0, ea = '0;
  logic [2*NE-1:0] ef = '0;
  logic [3:0]      fr = '0;
  logic [3:0]      iv;
  logic [4*IW-1:0] idx;
  logic [NE-1:0]   clr;
  logic            busy;

  int errors = 0;
  int checks = 0;

  rs_issue_scheduler #(.NUM_ENTRIES(NE), .IDX_W(IW), .FP_LATENCY(FPL)) dut (
    .clock_i       (clk),
    .reset_i       (rst_n),
    .entry_valid_i (ev),
    .entry_ready_i (er),
    .entry_fu_i    (ef),
    .entry_alloc_i (ea),
    .fu_ready_i    (fr),
    .issue_valid_o (iv),
    .issue_idx_o   (idx),
    .entry_clear_o (clr),
    .fp_busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: each entry carries an allocation sequence stamp; the
  // smallest stamp among eligible entries of a type wins, ties to lower index.
  logic [3:0]      exp_iv = '0;
  logic [4*IW-1:0] exp_idx = '0;
  logic [NE-1:0]   exp_clr = '0;
  logic            exp_busy = 1'b0;
  logic [NE-1:0]   m_iss = '0;
  int              stamp [NE];
  int              seq = 0;
  int              fpc = 0;

  initial for (int i = 0; i < NE; i++) stamp[i] = 0;

  always @(posedge clk or negedge rst_n) begin : mdl
    int best, nseq, ncnt;
    logic [3:0]      v;
    logic [4*IW-1:0] ix;
    logic [NE-1:0]   c;
    logic            e;
    if (!rst_n) begin
      exp_iv <= '0; exp_idx <= '0; exp_clr <= '0; exp_busy <= 1'b0;
      m_iss <= '0; fpc <= 0; seq <= 0;
      for (int i = 0; i < NE; i++) stamp[i] <= 0;
    end else begin
      v = '0; ix = '0; c = '0;
      for (int t = 0; t < 4; t++) begin
        best = -1;
        for (int i = 0; i < NE; i++) begin
          e = ev[i] && er[i] && (ef[2*i +: 2] == 2'(t)) && !m_iss[i] && !ea[i]
              && fr[t] && (t != 3 || fpc == 0);
          if (e && (best < 0 || stamp[i] < stamp[best])) best = i;
        end
        if (best >= 0) begin
          v[t] = 1'b1;
          ix[t*IW +: IW] = 3'(best);
          c[best] = 1'b1;
        end
      end
      nseq = seq;
      for (int i = 0; i < NE; i++) begin
        m_iss[i] <= (ea[i] || !ev[i]) ? 1'b0 : (m_iss[i] | c[i]);
        if (ea[i]) begin
          nseq++;
          stamp[i] <= nseq;
        end
      end
      seq  <= nseq;
      ncnt = v[3] ? FPL : (fpc > 0 ? fpc - 1 : 0);
      fpc  <= ncnt;
      exp_busy <= (ncnt != 0);
      exp_iv <= v; exp_idx <= ix; exp_clr <= c;
    end
  end

  always @(negedge clk) begin
    chk("cmp_issue_valid", int'(iv), int'(exp_iv));
    chk("cmp_issue_idx", int'(idx), int'(exp_idx));
    chk("cmp_entry_clear", int'(clr), int'(exp_clr));
    chk("cmp_fp_busy", int'(busy), int'(exp_busy));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_fu(input int i, input logic [1:0] c);
    ef[2*i +: 2] = c;
  endtask

  function automatic int fld(input logic [4*IW-1:0] v, input int t);
    return int'(v[t*IW +: IW]);
  endfunction

  initial begin
    // async reset with active inputs
    #1;
    rst_n = 1'b0; ev = '1; er = '1; ea = '1; ef = 10'b11_10_01_00_00; fr = 4'hf;
    #1;
    chk("rst_iv", int'(iv), 0);
    chk("rst_idx", int'(idx), 0);
    chk("rst_clr", int'(clr), 0);
    chk("rst_busy", int'(busy), 0);
    repeat (2) @(posedge clk);
    #1;
    ev = '0; er = '0; ea = '0; ef = '0; rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("idle_iv", int'(iv), 0);
    end

    // Load entry 3 allocated, then Load entry 1
    ev = 5'b01000; er = 5'b01000; ea = 5'b01000; set_fu(3, 2'd1); fr = 4'hf;
    tick(); chk("ld_alloc_iv", int'(iv), 0);
    ea = 5'b00010; ev = 5'b01010; er = 5'b01010; set_fu(1, 2'd1);
    tick();
    chk("ld_first_iv", int'(iv), 4'b0010);
    chk("ld_first_idx", fld(idx, 1), 3);
    chk("ld_first_clr", int'(clr), 5'b01000);
    ea = '0; ev = 5'b00010;
    tick();
    chk("ld_second_iv", int'(iv), 4'b0010);
    chk("ld_second_idx", fld(idx, 1), 1);
    chk("ld_second_clr", int'(clr), 5'b00010);
    ev = '0; er = '0;
    tick(); chk("ld_done_iv", int'(iv), 0);

    // four types at once
    ev = 5'b10111; er = 5'b10111;
    set_fu(0, 2'd0); set_fu(1, 2'd1); set_fu(2, 2'd2); set_fu(4, 2'd3);
    tick();
    chk("quad_iv", int'(iv), 4'b1111);
    chk("quad_idx", int'(idx), 12'b100_010_001_000);
    chk("quad_clr", int'(clr), 5'b10111);
    chk("quad_busy", int'(busy), 1);
    ev = '0; er = '0;
    repeat (5) tick();
    chk("quad_idle_busy", int'(busy), 0);

    // two FP entries, occupancy spacing
    ea = 5'b00011; ev = 5'b00011; er = 5'b00011; set_fu(0, 2'd3); set_fu(1, 2'd3);
    tick(); chk("fp_alloc_iv", int'(iv), 0);
    ea = '0;
    tick();
    chk("fp_first_iv", int'(iv), 4'b1000);
    chk("fp_first_idx", fld(idx, 3), 0);
    chk("fp_first_clr", int'(clr), 5'b00001);
    chk("fp_first_busy", int'(busy), 1);
    ev = 5'b00010; er = 5'b00010;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("fp_wait_iv", int'(iv), 0);
      chk("fp_wait_busy", int'(busy), 1);
    end
    tick();
    chk("fp_free_iv", int'(iv), 0);
    chk("fp_free_busy", int'(busy), 0);
    tick();
    chk("fp_second_iv", int'(iv), 4'b1000);
    chk("fp_second_idx", fld(idx, 3), 1);
    chk("fp_second_clr", int'(clr), 5'b00010);
    ev = '0; er = '0;
    repeat (5) tick();

    // Store stall on fu_ready
    ev = 5'b00100; er = 5'b00100; set_fu(2, 2'd2); fr = 4'b1011;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("st_stall_iv", int'(iv), 0);
    end
    fr = 4'hf;
    tick();
    chk("st_issue_iv", int'(iv), 4'b0100);
    chk("st_issue_idx", fld(idx, 2), 2);
    chk("st_issue_clr", int'(clr), 5'b00100);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("st_nodup_iv", int'(iv), 0);
    end
    ev = '0; er = '0;
    tick();

    // simultaneous alloc of ALU entries 2 and 4
    ea = 5'b10100; ev = 5'b10100; er = '0; set_fu(2, 2'd0); set_fu(4, 2'd0);
    tick(); chk("alu_alloc_iv", int'(iv), 0);
    ea = '0; er = 5'b10100;
    tick();
    chk("alu_first_iv", int'(iv), 4'b0001);
    chk("alu_first_idx", fld(idx, 0), 2);
    chk("alu_first_clr", int'(clr), 5'b00100);
    ev = 5'b10000; er = 5'b10000;
    tick();
    chk("alu_second_idx", fld(idx, 0), 4);
    chk("alu_second_clr", int'(clr), 5'b10000);
    ev = '0; er = '0;
    tick();

    // age beats index: entry 4 allocated before entry 0
    ea = 5'b10000; ev = 5'b10000; set_fu(4, 2'd1); set_fu(0, 2'd1);
    tick();
    ea = 5'b00001; ev = 5'b10001;
    tick();
    ea = '0; er = 5'b10001;
    tick();
    chk("age_first_idx", fld(idx, 1), 4);
    chk("age_first_clr", int'(clr), 5'b10000);
    ev = 5'b00001; er = 5'b00001;
    tick();
    chk("age_second_idx", fld(idx, 1), 0);
    chk("age_second_clr", int'(clr), 5'b00001);
    ev = '0; er = '0;
    tick();

    // reset mid-operation drops the grant immediately
    ev = 5'b00001; er = 5'b00001; set_fu(0, 2'd0);
    tick();
    chk("mid_pre_iv", int'(iv), 4'b0001);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_iv", int'(iv), 0);
    chk("mid_rst_clr", int'(clr), 0);
    chk("mid_rst_idx", int'(idx), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1; ev = '0; er = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
